pong_renderer: RTL and testbench
================================

// Module: pong_renderer
// PURPOSE
//  Display-side consumer of the Pong game state. Generates the game tick that
//  clocks the game controller and snapshots ball/paddle positions once per frame.
//  Maps the VGA timing position to a grid cell and drives 3-3-2 RGB through a
//  2-stage pipeline with matching sync delay. Counts goals per side.
//  Sits between the VGA timing generator and the DAC/pins.
// PARAMETERS
//  W            20     grid width in cells (ball X range 0..W-1)
//  H            15     grid height in cells (ball Y range 0..H-1)
//  CELL_LOG2    5      log2 of cell size in pixels (32 px: 640x480 -> 20x15)
//  PLAYER_SIZE  4      paddle spans rows pos..pos+PLAYER_SIZE inclusive
//  FRAMES_HALF  4      frames per GAME_CLK half-period (rising edge every 8 frames)
//  BALL_COLOR   8'hFF  ball color;  PADDLE_COLOR 8'h1C  paddle color
//  NET_COLOR    8'h92  net color;   BG_COLOR     8'h00  background color
//  SYNC_IDLE    1'b1   HSYNC/VSYNC level driven during reset
// PORTS
//  PIXEL_CLK    in   1   pixel clock, all logic on rising edge
//  RESET        in   1   synchronous, active-high
//  H_POS        in   10  current pixel column from timing generator
//  V_POS        in   10  current pixel row from timing generator
//  VIDEO_ON     in   1   1 = visible pixel
//  HSYNC_IN     in   1   raw hsync from timing generator
//  VSYNC_IN     in   1   raw vsync from timing generator
//  FRAME_START  in   1   one-cycle pulse at start of vertical blanking
//  BALL_X       in   5   ball cell column from game controller
//  BALL_Y       in   4   ball cell row
//  PLAYER_POS   in   4   left paddle top row
//  COM_POS      in   4   right paddle top row
//  GAME_CLK     out  1   registered game tick to the game controller
//  RGB          out  8   pixel color {R[2:0],G[2:0],B[1:0]}
//  HSYNC        out  1   HSYNC_IN delayed 2 cycles
//  VSYNC        out  1   VSYNC_IN delayed 2 cycles
//  SCORE_P      out  4   player goals, BCD 0..9 wrapping
//  SCORE_C      out  4   com goals, BCD 0..9 wrapping
// BEHAVIOUR
//  Reset: RGB=0, GAME_CLK=0, HSYNC=VSYNC=SYNC_IDLE, scores=0, frame count=0,
//   pipeline valid bits clear, snapshot = ball (10,7), paddles 7, prev X = 10.
//  Frame counter 0..FRAMES_HALF-1, advances only on FRAME_START; at
//   FRAMES_HALF-1 it wraps to 0 and GAME_CLK toggles in the same cycle.
//  Snapshot: on FRAME_START all four position inputs are registered; this uses
//   pre-toggle values, so a controller update from the same edge lands next frame.
//   Snapshot is held constant for the whole visible frame (no tearing).
//  Goals (on the FRAME_START cycle, comparing new snapshot X vs previous
//   snapshot X): new X==0 and prev!=0 -> SCORE_C+1; new X==W-1 and prev!=W-1 ->
//   SCORE_P+1. 9+1 -> 0. Ball parked at an edge for many frames counts once.
//  Stage 1 (cycle n+1): col=H_POS>>CELL_LOG2, row=V_POS>>CELL_LOG2, VIDEO_ON,
//   HSYNC_IN, VSYNC_IN registered.
//  Stage 2 (cycle n+2): color by priority, first match wins:
//   !video -> 8'h00; col>=W or row>=H -> BG; col==ballX && row==ballY -> BALL;
//   col==0 && PLAYER_POS<=row<=PLAYER_POS+PLAYER_SIZE -> PADDLE;
//   col==W-1 && COM_POS<=row<=COM_POS+PLAYER_SIZE -> PADDLE;
//   col==W/2 && row[0]==0 -> NET; else BG.
//  Paddle sum computed 5 bits wide (no 4-bit wrap). Latency fixed at 2 cycles
//   for RGB, HSYNC, VSYNC; all are mutually aligned.
//  FRAME_START with RESET high: reset wins. Reset mid-frame: outputs go to
//   reset values the next edge; pipeline refills in 2 cycles after release.
// TESTING
//  Reset 3 cycles, release -> RGB=0, GAME_CLK=0, SCORE_P=SCORE_C=0, HSYNC=1.
//  8 FRAME_START pulses -> GAME_CLK rises after 4th, falls after 8th, each same cycle as pulse.
//  Snapshot ball (3,4); drive H_POS=96,V_POS=128,VIDEO_ON=1 -> RGB=8'hFF exactly 2 cycles later.
//  PLAYER_POS=14; pixel (0,479) -> 8'h1C (row 14 in range, no 4-bit wrap); (0,416) -> 8'h00.
//  BALL_X 1->0 held 5 frames -> SCORE_C=1 once; repeat to 10 goals -> SCORE_C wraps to 0.
//  Change BALL_X mid-frame without FRAME_START -> RGB unchanged until next FRAME_START.

Source files
------------

// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - Pong display side: game tick, per-frame snapshot, goal scoring, 2-stage RGB pipeline.
module pong_renderer #(
  parameter int          W            = 20,
  parameter int          H            = 15,
  parameter int          CELL_LOG2    = 5,
  parameter int          PLAYER_SIZE  = 4,
  parameter int          FRAMES_HALF  = 4,
  parameter logic [7:0]  BALL_COLOR   = 8'hFF,
  parameter logic [7:0]  PADDLE_COLOR = 8'h1C,
  parameter logic [7:0]  NET_COLOR    = 8'h92,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter logic        SYNC_IDLE    = 1'b1
) (
  input  logic       i_pixel_clk,
  input  logic       i_reset,
  input  logic [9:0] i_h_pos,
  input  logic [9:0] i_v_pos,
  input  logic       i_video_on,
  input  logic       i_hsync_in,
  input  logic       i_vsync_in,
  input  logic       i_frame_start,
  input  logic [4:0] i_ball_x,
  input  logic [3:0] i_ball_y,
  input  logic [3:0] i_player_pos,
  input  logic [3:0] i_com_pos,
  output logic       o_game_clk,
  output logic [7:0] o_rgb,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [3:0] o_score_p,
  output logic [3:0] o_score_c
);

  localparam int CW  = 10 - CELL_LOG2;
  localparam int FCW = (FRAMES_HALF > 1) ? $clog2(FRAMES_HALF) : 1;
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAMES_HALF - 1);
  localparam logic [CW-1:0]  W_C      = CW'(W);
  localparam logic [CW-1:0]  H_C      = CW'(H);
  localparam logic [CW-1:0]  COL_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  COL_NET  = CW'(W / 2);
  localparam logic [4:0]     X_LAST   = 5'(W - 1);
  localparam logic [4:0]     PSIZE    = 5'(PLAYER_SIZE);

  logic [FCW-1:0] r_frame_cnt;
  logic           r_game_clk;
  logic [4:0]     r_ball_x;
  logic [3:0]     r_ball_y;
  logic [3:0]     r_player_pos;
  logic [3:0]     r_com_pos;
  logic [3:0]     r_score_p;
  logic [3:0]     r_score_c;

  logic [CW-1:0]  r_col;
  logic [CW-1:0]  r_row;
  logic           r_vid1;
  logic           r_hs1;
  logic           r_vs1;
  logic [7:0]     r_rgb;
  logic           r_hs2;
  logic           r_vs2;

  logic [7:0]     w_color;
  logic [4:0]     w_player_bot;
  logic [4:0]     w_com_bot;
  logic [4:0]     w_row5;
  logic           w_unused;

  assign w_unused = ^{i_h_pos[CELL_LOG2-1:0], i_v_pos[CELL_LOG2-1:0]};

  // Game tick, snapshot and scoring all move only on FRAME_START; the
  // snapshot register doubles as "previous X" for edge detection.
  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      r_frame_cnt  <= '0;
      r_game_clk   <= 1'b0;
      r_ball_x     <= 5'd10;
      r_ball_y     <= 4'd7;
      r_player_pos <= 4'd7;
      r_com_pos    <= 4'd7;
      r_score_p    <= 4'd0;
      r_score_c    <= 4'd0;
    end else if (i_frame_start) begin
      if (r_frame_cnt == FC_LAST) begin
        r_frame_cnt <= '0;
        r_game_clk  <= ~r_game_clk;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      r_ball_x     <= i_ball_x;
      r_ball_y     <= i_ball_y;
      r_player_pos <= i_player_pos;
      r_com_pos    <= i_com_pos;
      if (i_ball_x == 5'd0 && r_ball_x != 5'd0)
        r_score_c <= (r_score_c == 4'd9) ? 4'd0 : r_score_c + 4'd1;
      if (i_ball_x == X_LAST && r_ball_x != X_LAST)
        r_score_p <= (r_score_p == 4'd9) ? 4'd0 : r_score_p + 4'd1;
    end
  end

  // Paddle bounds are formed 5 bits wide so a paddle near the bottom does not wrap.
  assign w_player_bot = {1'b0, r_player_pos} + PSIZE;
  assign w_com_bot    = {1'b0, r_com_pos} + PSIZE;
  assign w_row5       = 5'(r_row);

  always_comb begin
    w_color = BG_COLOR;
    if (!r_vid1)
      w_color = 8'h00;
    else if (r_col >= W_C || r_row >= H_C)
      w_color = BG_COLOR;
    else if (r_col == CW'(r_ball_x) && r_row == CW'(r_ball_y))
      w_color = BALL_COLOR;
    else if (r_col == '0 && w_row5 >= {1'b0, r_player_pos} && w_row5 <= w_player_bot)
      w_color = PADDLE_COLOR;
    else if (r_col == COL_LAST && w_row5 >= {1'b0, r_com_pos} && w_row5 <= w_com_bot)
      w_color = PADDLE_COLOR;
    else if (r_col == COL_NET && !r_row[0])
      w_color = NET_COLOR;
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_vid1 <= 1'b0;
      r_hs1  <= SYNC_IDLE;
      r_vs1  <= SYNC_IDLE;
      r_rgb  <= 8'h00;
      r_hs2  <= SYNC_IDLE;
      r_vs2  <= SYNC_IDLE;
    end else begin
      r_col  <= i_h_pos[9:CELL_LOG2];
      r_row  <= i_v_pos[9:CELL_LOG2];
      r_vid1 <= i_video_on;
      r_hs1  <= i_hsync_in;
      r_vs1  <= i_vsync_in;
      r_rgb  <= w_color;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  assign o_game_clk = r_game_clk;
  assign o_rgb      = r_rgb;
  assign o_hsync    = r_hs2;
  assign o_vsync    = r_vs2;
  assign o_score_p  = r_score_p;
  assign o_score_c  = r_score_c;

endmodule

// File: tb/tb_pong_renderer.sv
// tb/tb_pong_renderer.sv - directed self-checking bench for pong_renderer.
module tb_pong_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_pos, v_pos;
  logic       video_on, hs_in, vs_in, frame_start;
  logic [4:0] ball_x;
  logic [3:0] ball_y, player_pos, com_pos;
  logic       game_clk, hsync, vsync;
  logic [7:0] rgb;
  logic [3:0] score_p, score_c;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pong_renderer dut (
    .i_pixel_clk  (clk),
    .i_reset      (rst),
    .i_h_pos      (h_pos),
    .i_v_pos      (v_pos),
    .i_video_on   (video_on),
    .i_hsync_in   (hs_in),
    .i_vsync_in   (vs_in),
    .i_frame_start(frame_start),
    .i_ball_x     (ball_x),
    .i_ball_y     (ball_y),
    .i_player_pos (player_pos),
    .i_com_pos    (com_pos),
    .o_game_clk   (game_clk),
    .o_rgb        (rgb),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_score_p    (score_p),
    .o_score_c    (score_c)
  );

  task automatic pulse_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic show_pixel(input logic [9:0] h, input logic [9:0] v, input logic von);
    @(negedge clk);
    h_pos = h; v_pos = v; video_on = von;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; hs_in = 1'b0; vs_in = 1'b0; video_on = 1'b1;
    h_pos = 10'd96; v_pos = 10'd128; frame_start = 1'b0;
    ball_x = 5'd10; ball_y = 4'd7; player_pos = 4'd7; com_pos = 4'd7;
    repeat (3) @(negedge clk);
    total++; if (hsync !== 1'b1) $display("FAIL reset_hsync got %b want 1", hsync); else passed++;
    total++; if (vsync !== 1'b1) $display("FAIL reset_vsync got %b want 1", vsync); else passed++;
    hs_in = 1'b1; vs_in = 1'b1; video_on = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++; if (rgb !== 8'h00) $display("FAIL reset_rgb got %h want 00", rgb); else passed++;
    total++; if (game_clk !== 1'b0) $display("FAIL reset_game_clk got %b want 0", game_clk); else passed++;
    total++; if (score_p !== 4'd0 || score_c !== 4'd0)
      $display("FAIL reset_scores got p=%0d c=%0d want 0/0", score_p, score_c); else passed++;
    total++; if (hsync !== 1'b1) $display("FAIL release_hsync got %b want 1", hsync); else passed++;
  endtask

  task automatic test_sync_delay();
    @(negedge clk) hs_in = 1'b0; vs_in = 1'b0;
    @(negedge clk);
    total++; if (hsync !== 1'b1 || vsync !== 1'b1)
      $display("FAIL sync_1cyc got h=%b v=%b want 1/1", hsync, vsync); else passed++;
    @(negedge clk);
    total++; if (hsync !== 1'b0 || vsync !== 1'b0)
      $display("FAIL sync_2cyc got h=%b v=%b want 0/0", hsync, vsync); else passed++;
    hs_in = 1'b1; vs_in = 1'b1;
  endtask

  task automatic test_game_clk();
    for (int i = 1; i <= 8; i++) begin
      pulse_frame();
      if (i == 3 || i == 4 || i == 7 || i == 8) begin
        total++;
        if (game_clk !== ((i == 4 || i == 7) ? 1'b1 : 1'b0))
          $display("FAIL game_clk_pulse%0d got %b want %b", i, game_clk, (i == 4 || i == 7));
        else passed++;
      end
    end
  endtask

  task automatic test_snapshot_ball();
    ball_x = 5'd3; ball_y = 4'd4; player_pos = 4'd14; com_pos = 4'd7;
    pulse_frame();
    @(negedge clk);
    h_pos = 10'd96; v_pos = 10'd128; video_on = 1'b1;
    @(negedge clk);
    total++; if (rgb !== 8'h00) $display("FAIL ball_lat1 got %h want 00", rgb); else passed++;
    @(negedge clk);
    total++; if (rgb !== 8'hFF) $display("FAIL ball_lat2 got %h want ff", rgb); else passed++;
    show_pixel(10'd96, 10'd128, 1'b0);
    total++; if (rgb !== 8'h00) $display("FAIL video_off got %h want 00", rgb); else passed++;
  endtask

  task automatic test_paddles_net();
    show_pixel(10'd0, 10'd479, 1'b1);
    total++; if (rgb !== 8'h1C) $display("FAIL player_row14 got %h want 1c", rgb); else passed++;
    show_pixel(10'd0, 10'd416, 1'b1);
    total++; if (rgb !== 8'h00) $display("FAIL player_row13 got %h want 00", rgb); else passed++;
    show_pixel(10'd608, 10'd224, 1'b1);
    total++; if (rgb !== 8'h1C) $display("FAIL com_top got %h want 1c", rgb); else passed++;
    show_pixel(10'd608, 10'd352, 1'b1);
    total++; if (rgb !== 8'h1C) $display("FAIL com_bottom got %h want 1c", rgb); else passed++;
    show_pixel(10'd608, 10'd384, 1'b1);
    total++; if (rgb !== 8'h00) $display("FAIL com_below got %h want 00", rgb); else passed++;
    show_pixel(10'd320, 10'd0, 1'b1);
    total++; if (rgb !== 8'h92) $display("FAIL net_even got %h want 92", rgb); else passed++;
    show_pixel(10'd320, 10'd32, 1'b1);
    total++; if (rgb !== 8'h00) $display("FAIL net_odd got %h want 00", rgb); else passed++;
    show_pixel(10'd640, 10'd128, 1'b1);
    total++; if (rgb !== 8'h00) $display("FAIL off_grid got %h want 00", rgb); else passed++;
  endtask

  task automatic test_no_tearing();
    ball_x = 5'd5;
    show_pixel(10'd96, 10'd128, 1'b1);
    total++; if (rgb !== 8'hFF) $display("FAIL tear_old got %h want ff", rgb); else passed++;
    show_pixel(10'd160, 10'd128, 1'b1);
    total++; if (rgb !== 8'h00) $display("FAIL tear_new got %h want 00", rgb); else passed++;
    pulse_frame();
    show_pixel(10'd160, 10'd128, 1'b1);
    total++; if (rgb !== 8'hFF) $display("FAIL snap_new got %h want ff", rgb); else passed++;
    show_pixel(10'd96, 10'd128, 1'b1);
    total++; if (rgb !== 8'h00) $display("FAIL snap_old got %h want 00", rgb); else passed++;
  endtask

  task automatic test_goals();
    ball_x = 5'd1; pulse_frame();
    total++; if (score_c !== 4'd0) $display("FAIL goal_none got %0d want 0", score_c); else passed++;
    ball_x = 5'd0;
    repeat (5) pulse_frame();
    total++; if (score_c !== 4'd1 || score_p !== 4'd0)
      $display("FAIL goal_c_once got c=%0d p=%0d want 1/0", score_c, score_p); else passed++;
    for (int g = 2; g <= 10; g++) begin
      ball_x = 5'd1; pulse_frame();
      ball_x = 5'd0; pulse_frame();
      if (g == 9) begin
        total++; if (score_c !== 4'd9) $display("FAIL goal_c_nine got %0d want 9", score_c); else passed++;
      end
    end
    total++; if (score_c !== 4'd0) $display("FAIL goal_c_wrap got %0d want 0", score_c); else passed++;
    ball_x = 5'd19;
    repeat (2) pulse_frame();
    total++; if (score_p !== 4'd1 || score_c !== 4'd0)
      $display("FAIL goal_p got p=%0d c=%0d want 1/0", score_p, score_c); else passed++;
  endtask

  task automatic test_reset_midframe();
    int budget = 8;
    while (game_clk !== 1'b1 && budget > 0) begin
      pulse_frame();
      budget--;
    end
    total++; if (game_clk !== 1'b1) $display("FAIL pre_reset_game_clk got %b want 1", game_clk); else passed++;
    @(negedge clk);
    rst = 1'b1; frame_start = 1'b1; ball_x = 5'd0;
    @(negedge clk);
    rst = 1'b0; frame_start = 1'b0;
    total++; if (game_clk !== 1'b0 || score_p !== 4'd0 || score_c !== 4'd0 || rgb !== 8'h00)
      $display("FAIL reset_wins got gclk=%b p=%0d c=%0d rgb=%h want 0/0/0/00",
               game_clk, score_p, score_c, rgb); else passed++;
    show_pixel(10'd320, 10'd224, 1'b1);
    total++; if (rgb !== 8'hFF) $display("FAIL reset_snapshot got %h want ff", rgb); else passed++;
    repeat (3) pulse_frame();
    total++; if (game_clk !== 1'b0) $display("FAIL cnt_reset_3 got %b want 0", game_clk); else passed++;
    pulse_frame();
    total++; if (game_clk !== 1'b1) $display("FAIL cnt_reset_4 got %b want 1", game_clk); else passed++;
    total++; if (score_c !== 4'd1) $display("FAIL post_reset_goal got %0d want 1", score_c); else passed++;
  endtask

  initial begin
    test_reset();
    test_sync_delay();
    test_game_clk();
    test_snapshot_ball();
    test_paddles_net();
    test_no_tearing();
    test_goals();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
